// File: rtl/adc_slot_capture.sv
// adc_slot_capture: reads 16-bit words from a serial ADC and re-times them onto a fixed slot grid.
// Build macro ADC_PARITY_CHECK_EN adds a trailing even-parity bit and discards words that fail it.
module adc_slot_capture #(
    parameter int SLOT_CYCLES = 256,
    parameter int SCLK_DIV    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        adc_drdy_n,
    input  logic        adc_sdo,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        slot_tick,
    output logic [15:0] sample_out,
    output logic        valid_out,
    output logic [15:0] miss_count,
    output logic        overrun,
    output logic [1:0]  read_state
);

`ifdef ADC_PARITY_CHECK_EN
    localparam int NBITS = 17;
`else
    localparam int NBITS = 16;
`endif

    localparam int DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BIT_W  = $clog2(NBITS + 1);
    localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NBITS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic drdy_s1;
    logic drdy_s2;
    logic drdy_prev;
    logic sdo_s1;
    logic sdo_s2;
    logic drdy_fall;

    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic              sclk_q;
    logic [NBITS-1:0]  shift_q;
    logic              div_last;

    logic [15:0]       word_data;
    logic              word_good;
    logic              word_done;

    logic [SLOT_W-1:0] slot_cnt;
    logic              boundary;
    logic              pending;
    logic [15:0]       pending_word;
    logic [15:0]       miss_cnt_q;

    // Both ADC inputs are asynchronous; synchronisers reset to the idle-high level.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            drdy_s1   <= 1'b1;
            drdy_s2   <= 1'b1;
            drdy_prev <= 1'b1;
            sdo_s1    <= 1'b1;
            sdo_s2    <= 1'b1;
        end else begin
            drdy_s1   <= adc_drdy_n;
            drdy_s2   <= drdy_s1;
            drdy_prev <= drdy_s2;
            sdo_s1    <= adc_sdo;
            sdo_s2    <= sdo_s1;
        end
    end

    assign drdy_fall = drdy_prev & ~drdy_s2;
    assign div_last  = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (drdy_fall) state_nxt = SETUP;
            SETUP:   if (div_last) state_nxt = SHIFT;
            SHIFT:   if (div_last && sclk_q && (bit_cnt == BIT_LAST)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        adc_cs_n   = 1'b1;
        adc_sclk   = sclk_q;
        read_state = state;
        if ((state == SETUP) || (state == SHIFT)) begin
            adc_cs_n = 1'b0;
        end
    end

    // Each bit is a low half then a high half; data is captured as sclk rises,
    // and the final falling edge is what hands the word over to DONE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            sclk_q  <= 1'b0;
            shift_q <= '0;
        end else begin
            case (state)
                SETUP: begin
                    div_cnt <= div_last ? '0 : (div_cnt + DIV_ONE);
                end
                SHIFT: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        sclk_q  <= ~sclk_q;
                        if (!sclk_q) begin
                            shift_q <= {shift_q[NBITS-2:0], sdo_s2};
                        end else begin
                            bit_cnt <= bit_cnt + BIT_ONE;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end
                end
                default: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    sclk_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ADC_PARITY_CHECK_EN
    assign word_data = shift_q[16:1];
    assign word_good = ((^shift_q[16:1]) == shift_q[0]);
`else
    assign word_data = shift_q[15:0];
    assign word_good = 1'b1;
`endif

    assign word_done = (state == DONE) && word_good;
    assign boundary  = (slot_cnt == SLOT_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= boundary ? '0 : (slot_cnt + SLOT_ONE);
        end
    end

    // A word landing on the boundary cycle is not seen by that tick: the tick
    // consumes the old pending state and the new word waits for the next one.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending      <= 1'b0;
            pending_word <= '0;
            overrun      <= 1'b0;
        end else if (word_done) begin
            pending      <= 1'b1;
            pending_word <= word_data;
            if (pending && !boundary) begin
                overrun <= 1'b1;
            end
        end else if (boundary) begin
            pending <= 1'b0;
        end
    end

    // valid_out qualifies sample_out for the slot just closed; both change only
    // together with slot_tick and hold otherwise. There is no back-pressure.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot_tick  <= 1'b0;
            sample_out <= '0;
            valid_out  <= 1'b0;
            miss_cnt_q <= '0;
        end else begin
            slot_tick <= boundary;
            if (boundary) begin
                if (pending) begin
                    sample_out <= pending_word;
                    valid_out  <= 1'b1;
                end else begin
                    sample_out <= '0;
                    valid_out  <= 1'b0;
                    if (miss_cnt_q != 16'hFFFF) begin
                        miss_cnt_q <= miss_cnt_q + 16'd1;
                    end
                end
            end
        end
    end

    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_adc_slot_capture.sv
// Bench for adc_slot_capture: directed ADC reads placed at known slot offsets, ticks checked by a scoreboard.
// Build with ADC_PARITY_CHECK_EN defined to also exercise the parity-reject path.
module tb_adc_slot_capture;

    localparam int SLOT = 64;
    localparam int SD   = 1;
`ifdef ADC_PARITY_CHECK_EN
    localparam int NB = 17;
`else
    localparam int NB = 16;
`endif
    // drdy driven in the cycle with slot position c puts DONE at c + 2*SD*NB + SD + 3
    localparam int RACE_POS = SLOT - 1 - (2 * SD * NB + SD + 3);

    logic        clk;
    logic        reset_n;
    logic        adc_drdy_n;
    logic        adc_sdo;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic        slot_tick;
    logic [15:0] sample_out;
    logic        valid_out;
    logic [15:0] miss_count;
    logic        overrun;
    logic [1:0]  read_state;

    logic [32:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    adc_slot_capture #(
        .SLOT_CYCLES(SLOT),
        .SCLK_DIV   (SD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .adc_drdy_n(adc_drdy_n),
        .adc_sdo   (adc_sdo),
        .adc_cs_n  (adc_cs_n),
        .adc_sclk  (adc_sclk),
        .slot_tick (slot_tick),
        .sample_out(sample_out),
        .valid_out (valid_out),
        .miss_count(miss_count),
        .overrun   (overrun),
        .read_state(read_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cycles since reset release; equals the slot counter position modulo SLOT
    always @(posedge clk) cyc <= reset_n ? cyc + 1 : 0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired, required normal completion");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic wait_cyc(input int unsigned t);
        int g;
        g = 0;
        while (cyc != t && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (cyc != t) begin
            checks++;
            errors++;
            $display("FAIL wait_cyc: at %0d, required %0d", cyc, t);
        end
    endtask

    function automatic logic [NB-1:0] make_word(input logic [15:0] d);
`ifdef ADC_PARITY_CHECK_EN
        return {d, ^d};
`else
        return d;
`endif
    endfunction

    task automatic push_exp(input logic v, input logic [15:0] s, input logic [15:0] m);
        exp_q.push_back({v, s, m});
    endtask

    // ADC model: MSB presented with drdy; each later bit is placed one cycle
    // ahead of the capture point so it survives the 2-flop synchroniser.
    task automatic adc_read(input logic [NB-1:0] w);
        int n;
        int k;
        int g;
        adc_sdo    = w[NB-1];
        adc_drdy_n = 1'b0;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (adc_cs_n && g < 10);
        if (adc_cs_n) begin
            checks++;
            errors++;
            $display("FAIL cs_n_assert: cs_n=%0b, required 0", adc_cs_n);
            adc_drdy_n = 1'b1;
            return;
        end
        n = 0;
        k = 1;
        while (k < NB) begin
            if (n == 2 * SD * (k + 1) - 3) begin
                adc_sdo = w[NB-1-k];
                k++;
            end
            @(negedge clk);
            n++;
        end
        g = 0;
        while (!adc_cs_n && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!adc_cs_n) begin
            checks++;
            errors++;
            $display("FAIL cs_n_release: cs_n=%0b, required 1", adc_cs_n);
        end
        adc_drdy_n = 1'b1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic        exp_tick;
        logic [32:0] e;
        exp_tick = (cyc % SLOT == 0) && (cyc != 0);
        if (slot_tick || exp_tick) begin
            chk("tick_timing", {31'd0, slot_tick}, {31'd0, exp_tick});
            if (slot_tick) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tick_unexpected: tick at cycle %0d, required none queued", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("tick_valid",  {31'd0, valid_out}, {31'd0, e[32]});
                    chk("tick_sample", {16'd0, sample_out}, {16'd0, e[31:16]});
                    chk("tick_miss",   {16'd0, miss_count}, {16'd0, e[15:0]});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int g;
        reset_n    = 1'b0;
        adc_drdy_n = 1'b1;
        adc_sdo    = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_cs_n",    {31'd0, adc_cs_n}, 32'd1);
        chk("rst_sclk",    {31'd0, adc_sclk}, 32'd0);
        chk("rst_tick",    {31'd0, slot_tick}, 32'd0);
        chk("rst_sample",  {16'd0, sample_out}, 32'd0);
        chk("rst_valid",   {31'd0, valid_out}, 32'd0);
        chk("rst_miss",    {16'd0, miss_count}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_state",   {30'd0, read_state}, 32'd0);
        reset_n = 1'b1;

        // slot 0 empty, slot 1 single read of a negative sample
        push_exp(1'b0, 16'h0000, 16'd1);
        wait_cyc(SLOT + 2);
        push_exp(1'b1, 16'h8001, 16'd1);
        adc_read(make_word(16'h8001));

        // slots 2..4 empty, slot 5 delivers 0x1234
        push_exp(1'b0, 16'h0000, 16'd2);
        push_exp(1'b0, 16'h0000, 16'd3);
        push_exp(1'b0, 16'h0000, 16'd4);
        wait_cyc(5 * SLOT + 2);
        push_exp(1'b1, 16'h1234, 16'd4);
        adc_read(make_word(16'h1234));

        // 0x0001 completes early in slot 6, 0x0002 overwrites it in the same slot
        wait_cyc(5 * SLOT + 45);
        adc_read(make_word(16'h0001));
        wait_cyc(6 * SLOT + 24);
        chk("overrun_clear", {31'd0, overrun}, 32'd0);
        chk("hold_sample", {16'd0, sample_out}, 32'h1234);
        push_exp(1'b1, 16'h0002, 16'd4);
        adc_read(make_word(16'h0002));
        wait_cyc(6 * SLOT + 63);
        chk("overrun_set", {31'd0, overrun}, 32'd1);

        // DONE lands on the last slot cycle: slot 7 is a miss, slot 8 carries the word
        push_exp(1'b0, 16'h0000, 16'd5);
        wait_cyc(7 * SLOT + RACE_POS);
        push_exp(1'b1, 16'hA5C3, 16'd5);
        adc_read(make_word(16'hA5C3));

        wait_cyc(9 * SLOT + 2);
        chk("queue_drained_1", exp_q.size(), 32'd0);

        // reset in the middle of a read
        adc_sdo    = 1'b1;
        adc_drdy_n = 1'b0;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (adc_cs_n && g < 10);
        repeat (16) @(negedge clk);
        chk("midread_state", {30'd0, read_state}, 32'd2);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midread_cs_n", {31'd0, adc_cs_n}, 32'd1);
        chk("midread_sclk", {31'd0, adc_sclk}, 32'd0);
        adc_drdy_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("midread_sample",  {16'd0, sample_out}, 32'd0);
        chk("midread_valid",   {31'd0, valid_out}, 32'd0);
        chk("midread_miss",    {16'd0, miss_count}, 32'd0);
        chk("midread_overrun", {31'd0, overrun}, 32'd0);
        reset_n = 1'b1;

        // the aborted read never shows up
        push_exp(1'b0, 16'h0000, 16'd1);
        push_exp(1'b0, 16'h0000, 16'd2);
`ifdef ADC_PARITY_CHECK_EN
        wait_cyc(2 * SLOT + 2);
        push_exp(1'b0, 16'h0000, 16'd3);
        adc_read({16'h0003, 1'b1});
        wait_cyc(3 * SLOT + 2);
        push_exp(1'b1, 16'h0003, 16'd3);
        adc_read({16'h0003, 1'b0});
`else
        push_exp(1'b0, 16'h0000, 16'd3);
        push_exp(1'b0, 16'h0000, 16'd4);
`endif

        // miss counter saturation
        wait_cyc(4 * SLOT + 10);
        force dut.miss_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.miss_cnt_q;
        chk("miss_forced", {16'd0, miss_count}, 32'h0000FFFE);
        push_exp(1'b0, 16'h0000, 16'hFFFF);
        push_exp(1'b0, 16'h0000, 16'hFFFF);
        push_exp(1'b0, 16'h0000, 16'hFFFF);

        wait_cyc(7 * SLOT + 4);
        chk("queue_drained_2", exp_q.size(), 32'd0);
        chk("final_overrun", {31'd0, overrun}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
